writeback_arbiter: RTL

Single-write-port arbiter that sits directly upstream of the register bank write port (`write_enable`/`rw`/`data`). It merges single-cycle ALU results with variable-latency load returns from the data cache. Load returns are buffered in a small FIFO, and a per-register pending-load scoreboard is kept so the issue stage can detect hazards. Outputs are registered and change on posedge, so the bank's negedge write lands in the same cycle the request is presented.

---
 rtl/writeback_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges single-cycle ALU results and buffered load
// returns onto one register-bank write port, with a pending-load scoreboard.
module writeback_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [7:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        ld_issue,
    input  logic [7:0]  ld_rd,
    input  logic        mem_valid,
    input  logic [7:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        write_enable,
    output logic [7:0]  rw,
    output logic [31:0] data,
    output logic [31:0] busy_mask,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [4:0]    r_fifo_rd   [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_busy;
    logic          r_ovf;
    logic          r_we;
    logic [7:0]    r_rw;
    logic [31:0]   r_data;

    logic        w_full;
    logic        w_empty;
    logic        w_alu_ok;
    logic        w_sel_head;
    logic        w_sel_alu;
    logic        w_push;
    logic        w_pop;
    logic [4:0]  w_head_rd;
    logic [31:0] w_head_data;
    logic [4:0]  w_win_rd;
    logic [31:0] w_win_data;
    logic [31:0] w_set;
    logic [31:0] w_clr;
    logic        w_unused;

    // Only the low five bits of each register index are meaningful.
    assign w_unused = ^{alu_rd[7:5], ld_rd[7:5], mem_rd[7:5]};

    assign w_full      = (r_count == C_DEPTH);
    assign w_empty     = (r_count == '0);
    assign w_head_rd   = r_fifo_rd[r_rptr];
    assign w_head_data = r_fifo_data[r_rptr];
    assign w_alu_ok    = alu_valid && !r_busy[alu_rd[4:0]];

    // Priority select: full FIFO, then hazard-free ALU, then queued load.
    always_comb begin
        w_sel_head = 1'b0;
        w_sel_alu  = 1'b0;
        if (reset) begin
            if (w_full) begin
                w_sel_head = 1'b1;
            end else if (w_alu_ok) begin
                w_sel_alu = 1'b1;
            end else if (!w_empty) begin
                w_sel_head = 1'b1;
            end
        end
    end

    assign w_win_rd   = w_sel_head ? w_head_rd : alu_rd[4:0];
    assign w_win_data = w_sel_head ? w_head_data : alu_data;

    assign mem_ready = (r_count < C_DEPTH) && reset;
    assign alu_stall = alu_valid && !w_sel_alu;
    assign w_push    = mem_valid && mem_ready;
    assign w_pop     = w_sel_head;

    assign w_set = (ld_issue && (ld_rd[4:0] != 5'd0))
                 ? (32'd1 << ld_rd[4:0]) : 32'd0;
    assign w_clr = w_pop ? (32'd1 << w_head_rd) : 32'd0;

    // Load-return storage; contents need no reset since count guards them.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= mem_rd[4:0];
            r_fifo_data[r_wptr] <= mem_data;
        end
    end

    // Pointers, occupancy, scoreboard, overflow and the registered write port.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_busy  <= '0;
            r_ovf   <= 1'b0;
            r_we    <= 1'b0;
            r_rw    <= '0;
            r_data  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_busy  <= ((r_busy & ~w_clr) | w_set) & ~32'd1;
            if (mem_valid && !mem_ready) begin
                r_ovf <= 1'b1;
            end
            if (w_sel_head || w_sel_alu) begin
                r_we   <= (w_win_rd != 5'd0);
                r_rw   <= {3'b000, w_win_rd};
                r_data <= w_win_data;
            end else begin
                r_we   <= 1'b0;
                r_rw   <= '0;
                r_data <= '0;
            end
        end
    end

    assign write_enable = r_we;
    assign rw           = r_rw;
    assign data         = r_data;
    assign busy_mask    = r_busy;
    assign overflow     = r_ovf;

endmodule
